crc5_check: RTL

CRC5_CHECK -- requirements
Module: crc5_check

---
 rtl/crc5_check.sv | 101 ++++++++++
 1 files changed

// File: rtl/crc5_check.sv
// Serial CRC-5 (x^5+x^2+1) packet checker: forwards payload bits through a 5-bit
// delay line so the trailing CRC is stripped, then reports pass/fail and length.
module crc5_check (
   input  logic       clk,
   input  logic       rst_L,
   input  logic       inb,
   input  logic       recving,
   input  logic       hold,
   output logic       outb,
   output logic       out_valid,
   output logic       done,
   output logic       crc_ok,
   output logic       crc_err,
   output logic [5:0] pkt_len
);

   // state   | meaning
   // S_IDLE  | waiting for the first accepted bit of a packet
   // S_RECV  | shifting packet bits, forwarding once the delay line is full
   // S_CHECK | one-cycle verdict (done=1), then back to S_IDLE
   typedef enum logic [1:0] {S_IDLE, S_RECV, S_CHECK} state_t;

   localparam logic [4:0] LFSR_INIT = 5'b11111;
   localparam logic [4:0] RESIDUAL  = 5'b01100;
   localparam logic [4:0] POLY_LOW  = 5'b00101;

   state_t     state_q, state_d;
   logic [4:0] lfsr_q, lfsr_nx;
   logic [4:0] dl_q;
   logic [2:0] fill_q;
   logic       ok_q, err_q;
   logic       accept;
   logic       pass;
   logic       full;

   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      done    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (recving && !hold) begin
               accept  = 1'b1;
               state_d = S_RECV;
            end
         end
         S_RECV: begin
            if (!recving)  state_d = S_CHECK;
            else if (!hold) accept = 1'b1;
         end
         S_CHECK: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign full      = (fill_q == 3'd5);
   assign lfsr_nx   = {lfsr_q[3:0], 1'b0} ^ ((lfsr_q[4] ^ inb) ? POLY_LOW : 5'b00000);
   assign pass      = full && (lfsr_q == RESIDUAL);
   assign out_valid = accept && full;
   assign outb      = out_valid & dl_q[4];

   // The verdict is visible during the done cycle itself, then held by the flops.
   assign crc_ok  = ok_q  | (done & pass);
   assign crc_err = err_q | (done & !pass);

   always_ff @(posedge clk or negedge rst_L) begin
      if (!rst_L) begin
         state_q <= S_IDLE;
         lfsr_q  <= LFSR_INIT;
         dl_q    <= 5'b00000;
         fill_q  <= 3'd0;
         ok_q    <= 1'b0;
         err_q   <= 1'b0;
         pkt_len <= 6'd0;
      end else begin
         state_q <= state_d;
         if (done) begin
            lfsr_q <= LFSR_INIT;
            dl_q   <= 5'b00000;
            fill_q <= 3'd0;
            ok_q   <= pass;
            err_q  <= !pass;
         end else if (accept) begin
            lfsr_q <= lfsr_nx;
            dl_q   <= {dl_q[3:0], inb};
            if (!full) fill_q <= fill_q + 3'd1;
         end
         if (state_q == S_IDLE && accept) begin
            ok_q    <= 1'b0;
            err_q   <= 1'b0;
            pkt_len <= 6'd0;
         end else if (out_valid && pkt_len != 6'd63) begin
            pkt_len <= pkt_len + 6'd1;
         end
      end
   end

endmodule
